// File: rtl/alarm_key_ctrl.sv
// Keypad entry controller for the alarm clock.
// Shifts up to four decimal digits into a key buffer, times out idle entries
// on one_second pulses, validates the buffer as HH:MM and issues single-cycle
// load strobes for the current-time counter or the alarm register.
module alarm_key_ctrl #(
    parameter int TIMEOUT_S = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_second,
    input  logic       key_valid,
    input  logic [3:0] key,
    input  logic       time_button,
    input  logic       alarm_button,
    output logic [3:0] new_current_time_ms_hr,
    output logic [3:0] new_current_time_ls_hr,
    output logic [3:0] new_current_time_ms_min,
    output logic [3:0] new_current_time_ls_min,
    output logic       load_new_c,
    output logic       load_new_a,
    output logic       show_new_time,
    output logic       show_a,
    output logic       reset_count,
    output logic [2:0] fsm_state
);

    localparam int TW = $clog2(TIMEOUT_S + 1);

    typedef enum logic [2:0] {
        SHOW_TIME        = 3'd0,
        KEY_ENTRY        = 3'd1,
        SHOW_ALARM       = 3'd2,
        SET_CURRENT_TIME = 3'd3,
        SET_ALARM_TIME   = 3'd4
    } state_t;

    state_t         state, nxt_state;
    // Key buffer packed as {ms_hr, ls_hr, ms_min, ls_min}.
    logic [15:0]    key_buf, nxt_buf;
    logic [2:0]     digit_cnt, nxt_cnt;
    logic [TW-1:0]  tmo_cnt, nxt_tmo;

    logic           key_ok;
    logic           entry_ok;
    logic           tmo_hit;
    logic [15:0]    shifted_buf;
    logic [2:0]     sat_cnt;

    assign fsm_state              = state;
    assign new_current_time_ms_hr  = key_buf[15:12];
    assign new_current_time_ls_hr  = key_buf[11:8];
    assign new_current_time_ms_min = key_buf[7:4];
    assign new_current_time_ls_min = key_buf[3:0];

    // Decode the per-cycle helper terms: legal digit, HH:MM validity, timeout.
    always_comb begin
        key_ok      = key_valid && (key <= 4'd9);
        shifted_buf = {key_buf[11:0], key};
        sat_cnt     = (digit_cnt >= 3'd4) ? 3'd4 : digit_cnt + 3'd1;
        tmo_hit     = one_second && (tmo_cnt == TW'(TIMEOUT_S - 1));
        entry_ok    = (digit_cnt == 3'd4)
                   && (key_buf[15:12] <= 4'd2)
                   && (key_buf[11:8]  <= 4'd9)
                   && !((key_buf[15:12] == 4'd2) && (key_buf[11:8] > 4'd3))
                   && (key_buf[7:4]   <= 4'd5)
                   && (key_buf[3:0]   <= 4'd9);
    end

    // Next-state, key buffer, digit count and timeout decisions.
    // Event priority: time_button, then alarm_button, then a legal digit,
    // then one_second; only the first present event is acted on.
    always_comb begin
        nxt_state = state;
        nxt_buf   = key_buf;
        nxt_cnt   = digit_cnt;
        nxt_tmo   = tmo_cnt;
        case (state)
            SHOW_TIME: begin
                if (time_button) begin
                    nxt_state = SHOW_TIME;
                end else if (alarm_button) begin
                    nxt_state = SHOW_ALARM;
                    nxt_tmo   = '0;
                end else if (key_ok) begin
                    nxt_state = KEY_ENTRY;
                    nxt_buf   = shifted_buf;
                    nxt_cnt   = sat_cnt;
                    nxt_tmo   = '0;
                end
            end
            KEY_ENTRY: begin
                if (time_button || alarm_button) begin
                    if (entry_ok) begin
                        // Buffer holds through the one-cycle SET state.
                        nxt_state = time_button ? SET_CURRENT_TIME : SET_ALARM_TIME;
                    end else begin
                        nxt_state = SHOW_TIME;
                        nxt_buf   = '0;
                        nxt_cnt   = '0;
                        nxt_tmo   = '0;
                    end
                end else if (key_ok) begin
                    nxt_buf = shifted_buf;
                    nxt_cnt = sat_cnt;
                    nxt_tmo = '0;
                end else if (one_second) begin
                    if (tmo_hit) begin
                        nxt_state = SHOW_TIME;
                        nxt_buf   = '0;
                        nxt_cnt   = '0;
                        nxt_tmo   = '0;
                    end else begin
                        nxt_tmo = tmo_cnt + TW'(1);
                    end
                end
            end
            SHOW_ALARM: begin
                // Any event is consumed; a digit is not shifted in.
                if (time_button || alarm_button || key_ok) begin
                    nxt_state = SHOW_TIME;
                    nxt_tmo   = '0;
                end else if (one_second) begin
                    if (tmo_hit) begin
                        nxt_state = SHOW_TIME;
                        nxt_tmo   = '0;
                    end else begin
                        nxt_tmo = tmo_cnt + TW'(1);
                    end
                end
            end
            SET_CURRENT_TIME, SET_ALARM_TIME: begin
                nxt_state = SHOW_TIME;
                nxt_buf   = '0;
                nxt_cnt   = '0;
                nxt_tmo   = '0;
            end
            default: begin
                nxt_state = SHOW_TIME;
                nxt_buf   = '0;
                nxt_cnt   = '0;
                nxt_tmo   = '0;
            end
        endcase
    end

    // State register with Moore outputs registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= SHOW_TIME;
            key_buf       <= '0;
            digit_cnt     <= '0;
            tmo_cnt       <= '0;
            load_new_c    <= 1'b0;
            load_new_a    <= 1'b0;
            show_new_time <= 1'b0;
            show_a        <= 1'b0;
            reset_count   <= 1'b0;
        end else begin
            state         <= nxt_state;
            key_buf       <= nxt_buf;
            digit_cnt     <= nxt_cnt;
            tmo_cnt       <= nxt_tmo;
            load_new_c    <= (nxt_state == SET_CURRENT_TIME);
            load_new_a    <= (nxt_state == SET_ALARM_TIME);
            show_new_time <= (nxt_state == KEY_ENTRY) ||
                             (nxt_state == SET_CURRENT_TIME) ||
                             (nxt_state == SET_ALARM_TIME);
            show_a        <= (nxt_state == SHOW_ALARM);
            reset_count   <= (nxt_state == SET_CURRENT_TIME);
        end
    end

endmodule

// File: tb/tb_alarm_key_ctrl.sv
// Directed bench for alarm_key_ctrl: a vector table for the key/button
// scenarios plus hand sequences for timeouts and asynchronous reset.
module tb_alarm_key_ctrl;

    // Flag order: {load_new_c, load_new_a, show_new_time, show_a, reset_count}
    localparam logic [4:0] F_IDLE  = 5'b00000;
    localparam logic [4:0] F_ENTRY = 5'b00100;
    localparam logic [4:0] F_ALARM = 5'b00010;
    localparam logic [4:0] F_SETC  = 5'b10101;
    localparam logic [4:0] F_SETA  = 5'b01100;
    localparam logic [2:0] S_ST = 3'd0, S_KE = 3'd1, S_SA = 3'd2, S_SC = 3'd3, S_SAT = 3'd4;

    typedef struct packed {
        logic        tb;
        logic        ab;
        logic        kv;
        logic [3:0]  key;
        logic        os;
        logic [15:0] digits;
        logic [4:0]  flags;
        logic [2:0]  st;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       one_second = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key = 4'd0;
    logic       time_button = 1'b0;
    logic       alarm_button = 1'b0;
    logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
    logic       load_new_c, load_new_a, show_new_time, show_a, reset_count;
    logic [2:0] fsm_state;

    int tests = 0;
    int fails = 0;
    vec_t vecs[$];

    alarm_key_ctrl #(.TIMEOUT_S(10)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .one_second              (one_second),
        .key_valid               (key_valid),
        .key                     (key),
        .time_button             (time_button),
        .alarm_button            (alarm_button),
        .new_current_time_ms_hr  (ms_hr),
        .new_current_time_ls_hr  (ls_hr),
        .new_current_time_ms_min (ms_min),
        .new_current_time_ls_min (ls_min),
        .load_new_c              (load_new_c),
        .load_new_a              (load_new_a),
        .show_new_time           (show_new_time),
        .show_a                  (show_a),
        .reset_count             (reset_count),
        .fsm_state               (fsm_state)
    );

    // Clock generation
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic tb_i, input logic ab_i, input logic kv_i,
                                input logic [3:0] key_i, input logic os_i,
                                input logic [15:0] d, input logic [4:0] f, input logic [2:0] s);
        vec_t v;
        v.tb = tb_i; v.ab = ab_i; v.kv = kv_i; v.key = key_i; v.os = os_i;
        v.digits = d; v.flags = f; v.st = s;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] d,
                         input logic [4:0] f, input logic [2:0] s);
        logic [15:0] ad;
        logic [4:0]  af;
        ad = {ms_hr, ls_hr, ms_min, ls_min};
        af = {load_new_c, load_new_a, show_new_time, show_a, reset_count};
        tests++;
        if (ad !== d || af !== f || fsm_state !== s) begin
            fails++;
            $display("FAIL %s: got digits=%h flags=%b state=%0d, want digits=%h flags=%b state=%0d",
                     name, ad, af, fsm_state, d, f, s);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, sample just after the rising edge
    task automatic step(input logic tb_i, input logic ab_i, input logic kv_i,
                        input logic [3:0] key_i, input logic os_i);
        @(negedge clk);
        time_button = tb_i; alarm_button = ab_i; key_valid = kv_i; key = key_i; one_second = os_i;
        @(posedge clk);
        #1;
        time_button = 1'b0; alarm_button = 1'b0; key_valid = 1'b0; one_second = 1'b0;
    endtask

    task automatic press(input logic [3:0] k);
        step(1'b0, 1'b0, 1'b1, k, 1'b0);
    endtask

    task automatic pulse_sec();
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    endtask

    initial begin
        // Load: 5 then 1,2,3,4 keeps the last four; time_button loads
        vecs.push_back(mk(0,0,1,4'd5,0, 16'h0005, F_ENTRY, S_KE));
        vecs.push_back(mk(0,0,1,4'd1,0, 16'h0051, F_ENTRY, S_KE));
        vecs.push_back(mk(0,0,1,4'd2,0, 16'h0512, F_ENTRY, S_KE));
        vecs.push_back(mk(0,0,1,4'd3,0, 16'h5123, F_ENTRY, S_KE));
        vecs.push_back(mk(0,0,1,4'd4,0, 16'h1234, F_ENTRY, S_KE));
        vecs.push_back(mk(1,0,0,4'd0,0, 16'h1234, F_SETC,  S_SC));
        vecs.push_back(mk(0,0,0,4'd0,0, 16'h0000, F_IDLE,  S_ST));
        // 24:00 is not a valid time: alarm_button aborts
        vecs.push_back(mk(0,0,1,4'd2,0, 16'h0002, F_ENTRY, S_KE));
        vecs.push_back(mk(0,0,1,4'd4,0, 16'h0024, F_ENTRY, S_KE));
        vecs.push_back(mk(0,0,1,4'd0,0, 16'h0240, F_ENTRY, S_KE));
        vecs.push_back(mk(0,0,1,4'd0,0, 16'h2400, F_ENTRY, S_KE));
        vecs.push_back(mk(0,1,0,4'd0,0, 16'h0000, F_IDLE,  S_ST));
        // Only two digits: no load
        vecs.push_back(mk(0,0,1,4'd1,0, 16'h0001, F_ENTRY, S_KE));
        vecs.push_back(mk(0,0,1,4'd2,0, 16'h0012, F_ENTRY, S_KE));
        vecs.push_back(mk(1,0,0,4'd0,0, 16'h0000, F_IDLE,  S_ST));
        // Minutes tens digit 6 is invalid
        vecs.push_back(mk(0,0,1,4'd1,0, 16'h0001, F_ENTRY, S_KE));
        vecs.push_back(mk(0,0,1,4'd2,0, 16'h0012, F_ENTRY, S_KE));
        vecs.push_back(mk(0,0,1,4'd6,0, 16'h0126, F_ENTRY, S_KE));
        vecs.push_back(mk(0,0,1,4'd0,0, 16'h1260, F_ENTRY, S_KE));
        vecs.push_back(mk(1,0,0,4'd0,0, 16'h0000, F_IDLE,  S_ST));
        // Simultaneous time_button, alarm_button, digit: load_new_c wins
        vecs.push_back(mk(0,0,1,4'd0,0, 16'h0000, F_ENTRY, S_KE));
        vecs.push_back(mk(0,0,1,4'd9,0, 16'h0009, F_ENTRY, S_KE));
        vecs.push_back(mk(0,0,1,4'd3,0, 16'h0093, F_ENTRY, S_KE));
        vecs.push_back(mk(0,0,1,4'd0,0, 16'h0930, F_ENTRY, S_KE));
        vecs.push_back(mk(1,1,1,4'd7,0, 16'h0930, F_SETC,  S_SC));
        vecs.push_back(mk(0,0,0,4'd0,0, 16'h0000, F_IDLE,  S_ST));
        // 23:59 into the alarm register
        vecs.push_back(mk(0,0,1,4'd2,0, 16'h0002, F_ENTRY, S_KE));
        vecs.push_back(mk(0,0,1,4'd3,0, 16'h0023, F_ENTRY, S_KE));
        vecs.push_back(mk(0,0,1,4'd5,0, 16'h0235, F_ENTRY, S_KE));
        vecs.push_back(mk(0,0,1,4'd9,0, 16'h2359, F_ENTRY, S_KE));
        vecs.push_back(mk(0,1,0,4'd0,0, 16'h2359, F_SETA,  S_SAT));
        vecs.push_back(mk(0,0,0,4'd0,0, 16'h0000, F_IDLE,  S_ST));
        // SHOW_TIME ignores time_button and illegal keys
        vecs.push_back(mk(1,0,0,4'd0,0, 16'h0000, F_IDLE,  S_ST));
        vecs.push_back(mk(0,0,1,4'd11,0,16'h0000, F_IDLE,  S_ST));
        // Show alarm, illegal key ignored, legal key returns without shifting
        vecs.push_back(mk(0,1,0,4'd0,0, 16'h0000, F_ALARM, S_SA));
        vecs.push_back(mk(0,0,1,4'd12,0,16'h0000, F_ALARM, S_SA));
        vecs.push_back(mk(0,0,1,4'd3,0, 16'h0000, F_IDLE,  S_ST));
        // Illegal key in KEY_ENTRY leaves the buffer alone
        vecs.push_back(mk(0,0,1,4'd8,0, 16'h0008, F_ENTRY, S_KE));
        vecs.push_back(mk(0,0,1,4'd15,0,16'h0008, F_ENTRY, S_KE));
        vecs.push_back(mk(1,0,0,4'd0,0, 16'h0000, F_IDLE,  S_ST));

        // Reset block
        repeat (3) @(posedge clk);
        #1;
        check("reset_held", 16'h0000, F_IDLE, S_ST);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_released", 16'h0000, F_IDLE, S_ST);

        // Vector table
        foreach (vecs[i]) begin
            step(vecs[i].tb, vecs[i].ab, vecs[i].kv, vecs[i].key, vecs[i].os);
            check($sformatf("vec%0d", i), vecs[i].digits, vecs[i].flags, vecs[i].st);
        end

        // Timeout restart: a digit after the 5th pulse restarts the count
        press(4'd0);
        check("to_key0", 16'h0000, F_ENTRY, S_KE);
        press(4'd7);
        check("to_key7", 16'h0007, F_ENTRY, S_KE);
        for (int i = 0; i < 5; i++) begin
            pulse_sec();
            check($sformatf("to_pre%0d", i + 1), 16'h0007, F_ENTRY, S_KE);
        end
        press(4'd1);
        check("to_restart", 16'h0071, F_ENTRY, S_KE);
        for (int i = 0; i < 9; i++) begin
            pulse_sec();
            check($sformatf("to_a%0d", i + 1), 16'h0071, F_ENTRY, S_KE);
        end
        // Coincident one_second and digit: digit wins, count cleared
        step(1'b0, 1'b0, 1'b1, 4'd2, 1'b1);
        check("to_coincident", 16'h0712, F_ENTRY, S_KE);
        for (int i = 0; i < 9; i++) begin
            pulse_sec();
            check($sformatf("to_b%0d", i + 1), 16'h0712, F_ENTRY, S_KE);
        end
        pulse_sec();
        check("to_fire", 16'h0000, F_IDLE, S_ST);

        // SHOW_ALARM timeout
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        check("sa_enter", 16'h0000, F_ALARM, S_SA);
        for (int i = 0; i < 9; i++) begin
            pulse_sec();
            check($sformatf("sa_p%0d", i + 1), 16'h0000, F_ALARM, S_SA);
        end
        pulse_sec();
        check("sa_fire", 16'h0000, F_IDLE, S_ST);

        // Asynchronous reset mid-entry
        press(4'd1);
        press(4'd2);
        check("rst_entry_pre", 16'h0012, F_ENTRY, S_KE);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_entry_async", 16'h0000, F_IDLE, S_ST);
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        check("rst_entry_after", 16'h0000, F_IDLE, S_ST);

        // Asynchronous reset during SET_CURRENT_TIME kills the strobe
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        check("rst_set_pre", 16'h1234, F_SETC, S_SC);
        #2;
        reset = 1'b0;
        #1;
        check("rst_set_async", 16'h0000, F_IDLE, S_ST);
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        check("rst_set_after", 16'h0000, F_IDLE, S_ST);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alarm_key_ctrl.md
# alarm_key_ctrl

Keypad entry controller of the alarm clock. It collects up to four decimal digits into a shifting key buffer, times out idle entries on `one_second` pulses, and validates the entry as an HH:MM time. It then issues the single-cycle `load_new_c` (current time) or `load_new_a` (alarm time) strobe, together with `show_new_time` and `show_a` display selects. The block sits directly upstream of the counter: its `new_current_time_*` digits and `load_new_c` drive the counter's load port.

## Interface
- `TIMEOUT_S`, default 10: idle seconds in KEY_ENTRY or SHOW_ALARM before returning to SHOW_TIME.
- `clk` input 1: system clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `one_second` input 1: one-cycle pulse once per second, from the time generator.
- `key_valid` input 1: one-cycle pulse per keypad press; `key` is sampled in that cycle.
- `key` input 4: pressed digit; only values 0–9 are legal, and 10–15 are ignored.
- `time_button` input 1: one-cycle pulse, "set current time".
- `alarm_button` input 1: one-cycle pulse, "set or show alarm".
- `new_current_time_ms_hr`, `new_current_time_ls_hr`, `new_current_time_ms_min`, `new_current_time_ls_min` output 4 each: key buffer digits, registered.
- `load_new_c` output 1: load the buffer into the current-time counter.
- `load_new_a` output 1: load the buffer into the alarm register.
- `show_new_time` output 1: display the key buffer.
- `show_a` output 1: display the alarm time.
- `reset_count` output 1: restart the seconds prescaler; asserted together with `load_new_c`.

## Operation
- **States:** SHOW_TIME, KEY_ENTRY, SHOW_ALARM, SET_CURRENT_TIME, SET_ALARM_TIME.
- **Outputs:** all outputs are registered, Moore-decoded from the state.
  - SHOW_TIME: all strobes 0.
  - KEY_ENTRY: `show_new_time` = 1.
  - SHOW_ALARM: `show_a` = 1.
  - SET_CURRENT_TIME: `load_new_c` = 1, `reset_count` = 1, `show_new_time` = 1.
  - SET_ALARM_TIME: `load_new_a` = 1, `show_new_time` = 1.
- **Event priority in one cycle:** `time_button` > `alarm_button` > `key_valid`. Only the highest-priority event is acted on.
- **Digit shift:** on a legal digit, the buffer shifts left:
  - ms_hr ← ls_hr
  - ls_hr ← ms_min
  - ms_min ← ls_min
  - ls_min ← key
  - The 3-bit digit count increments and saturates at 4. Digits beyond the fourth keep shifting, so the last four are kept.
- **Valid entry:** count == 4, ms_hr ≤ 2, ls_hr ≤ 9, ls_hr ≤ 3 when ms_hr == 2, ms_min ≤ 5, ls_min ≤ 9.
- **SHOW_TIME:**
  - Legal digit: shift it in and go to KEY_ENTRY.
  - `alarm_button`: go to SHOW_ALARM.
  - `time_button`: ignored.
- **KEY_ENTRY:**
  - Legal digit: shift it in and clear the timeout.
  - `time_button`: go to SET_CURRENT_TIME if the entry is valid. Otherwise go to SHOW_TIME and clear the buffer.
  - `alarm_button`: go to SET_ALARM_TIME if the entry is valid, else abort the same way.
  - Timeout: go to SHOW_TIME and clear the buffer.
- **SET_CURRENT_TIME / SET_ALARM_TIME:**
  - Exactly one cycle; all inputs are ignored.
  - The buffer holds its value during this cycle, then clears as the block enters SHOW_TIME.
- **SHOW_ALARM:** any `key_valid`, `time_button`, `alarm_button` or timeout returns to SHOW_TIME. The event is consumed, and a digit is not shifted in.
- **Timeout counter:**
  - Width is `$clog2(TIMEOUT_S+1)`.
  - It is cleared on entry to KEY_ENTRY or SHOW_ALARM, and on every legal digit.
  - It increments on `one_second` while in KEY_ENTRY or SHOW_ALARM.
  - Timeout fires in the cycle the counter reaches `TIMEOUT_S`.
- **Illegal keys:** a `key_valid` with key > 9 causes no state, buffer, count or timeout change.

## Timing
- **Reset (`reset` low):** state = SHOW_TIME; buffer digits, count and timeout = 0; every output = 0. Reset is immediate and asynchronous, also mid-entry or during a SET state; no load strobe is issued.
- **Digit latency:** a digit sampled on edge N appears on `new_current_time_*` after edge N.
- **Load latency:** `time_button` sampled on edge N makes `load_new_c` high for exactly the cycle after edge N. The buffer is stable during that cycle, so the counter loads on edge N+1.
- **Strobe timing:** `load_new_c` and `load_new_a` are never both high. Neither is high for more than one consecutive cycle.
- **Timeout edge:** the `TIMEOUT_S`-th `one_second` pulse sampled on edge N makes the state SHOW_TIME after edge N. The `(TIMEOUT_S−1)`-th pulse does not.
- **Coincident `one_second` and legal digit:** the digit wins, and the timeout is cleared rather than incremented.

## Test plan
- **Reset values:** release `reset` → all outputs 0 and state SHOW_TIME. Press 5 → buffer reads 0,0,0,5 and `show_new_time` = 1.
- **Valid current-time load:** keys 1,2,3,4 then `time_button` → one-cycle `load_new_c` and `reset_count` with digits 1,2,3,4. Next cycle: buffer 0,0,0,0, `show_new_time` = 0.
- **Invalid entries:**
  - Keys 2,4,0,0 then `alarm_button` → no `load_new_a`; state SHOW_TIME; buffer cleared.
  - Keys 1,2 then `time_button` (count 2) → no load.
- **Timeout:** keys 0,7 then 9 `one_second` pulses → still KEY_ENTRY. The 10th pulse → SHOW_TIME with buffer 0. A key after the 5th pulse restarts the count.
- **Simultaneous events:** in KEY_ENTRY with 0,9,3,0 entered, pulse `time_button`, `alarm_button` and digit 7 in the same cycle → `load_new_c` only, digits 0,9,3,0.
- **Show alarm, illegal key, reset mid-entry:**
  - `alarm_button` in SHOW_TIME → `show_a` = 1.
  - Key 12 → no change.
  - Key 3 → SHOW_TIME, buffer unchanged at 0.
  - Assert `reset` after keys 1,2 → all outputs 0 immediately.
